multi_bank_pixel_buffer: RTL and testbench



---
 rtl/mbpb_pkg.sv | 36 +++
 rtl/mbpb_bank_ram.sv | 44 ++++
 rtl/multi_bank_pixel_buffer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_multi_bank_pixel_buffer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mbpb_pkg.sv
// Shared types and constants for multi_bank_pixel_buffer: bank state, fetch FSM states,
// AXI field constants and the self-test colour table.
package mbpb_pkg;

  typedef enum logic {
    BankEmpty = 1'b0,
    BankFull  = 1'b1
  } bank_state_e;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } fetch_state_e;

  localparam logic [1:0] AxiBurstIncr = 2'b01;
  localparam logic [1:0] AxiRespOkay  = 2'b00;

  // RGB444 colour bars: black, white, red, green, blue, yellow, cyan, magenta.
  function automatic logic [11:0] colour_bar(input logic [2:0] idx);
    logic [11:0] rgb;
    rgb = 12'h000;
    unique case (idx)
      3'd0: rgb = 12'h000;
      3'd1: rgb = 12'hFFF;
      3'd2: rgb = 12'hF00;
      3'd3: rgb = 12'h0F0;
      3'd4: rgb = 12'h00F;
      3'd5: rgb = 12'hFF0;
      3'd6: rgb = 12'h0FF;
      3'd7: rgb = 12'hF0F;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/mbpb_bank_ram.sv
// One line bank: Depth x Width storage with one write port and one registered read port.
module mbpb_bank_ram #(
  parameter int unsigned Depth = 32,
  parameter int unsigned Width = 64,
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register only moves on an enabled read so the pixel output holds otherwise.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/multi_bank_pixel_buffer.sv
// Ring of line banks filled by AXI4 INCR bursts and drained one pixel per request.
// Optional colour-bar source enabled by defining MBPB_SELF_TEST_EN.
module multi_bank_pixel_buffer
  import mbpb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned SLOT_WIDTH = 16,
  parameter int unsigned PIX_WIDTH  = 12,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned BURST_LEN  = 32
) (
  input  logic                  clk_a,
  input  logic                  reset_a,
  input  logic                  enable_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] top_addr_i,
  input  logic                  data_req_i,
  output logic [PIX_WIDTH-1:0]  data_o,
  output logic                  data_valid_o,
  output logic                  underrun_o,
  output logic                  resp_err_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [7:0]            arlen_o,
  output logic [2:0]            arsize_o,
  output logic [1:0]            arburst_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i,
  input  logic                  rvalid_i,
  output logic                  rready_o
`ifdef MBPB_SELF_TEST_EN
  ,
  input  logic                  self_test_i
`endif
);

  localparam int unsigned PixPerBeat = DATA_WIDTH / SLOT_WIDTH;
  localparam int unsigned BurstBytes = BURST_LEN * DATA_WIDTH / 8;
  localparam int unsigned BankW      = $clog2(NUM_BANKS);
  localparam int unsigned BeatW      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned SlotW      = (PixPerBeat > 1) ? $clog2(PixPerBeat) : 1;

  assign arlen_o   = 8'(BURST_LEN - 1);
  assign arsize_o  = 3'($clog2(DATA_WIDTH / 8));
  assign arburst_o = AxiBurstIncr;

  fetch_state_e          state_q, state_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [BeatW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [BankW-1:0]      wr_bank_q, wr_bank_d;
  logic                  resp_err_q, resp_err_d;
  bank_state_e           bank_q [NUM_BANKS];
  bank_state_e           bank_d [NUM_BANKS];
  logic [BankW-1:0]      rd_bank_q, rd_bank_d;
  logic [BeatW-1:0]      rd_beat_q, rd_beat_d;
  logic [SlotW-1:0]      rd_slot_q, rd_slot_d;
  logic [BankW-1:0]      pix_bank_q, pix_bank_d;
  logic [SlotW-1:0]      pix_slot_q, pix_slot_d;
  logic                  data_valid_q, data_valid_d;
  logic                  underrun_q, underrun_d;

  logic                  ar_fire, beat_fire, last_beat, bank_set, bank_clr;
  logic                  rd_full, serve, st_mode;
  logic [ADDR_WIDTH:0]   addr_sum;
  logic [DATA_WIDTH-1:0] ram_rdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [PIX_WIDTH-1:0]  ram_pix;

`ifdef MBPB_SELF_TEST_EN
  assign st_mode = self_test_i;
`else
  assign st_mode = 1'b0;
`endif

  assign ar_fire   = arvalid_q & arready_i;
  assign beat_fire = rvalid_i & rready_q;
  assign last_beat = beat_fire & (rlast_i | (beat_cnt_q == BeatW'(BURST_LEN - 1)));
  assign addr_sum  = {1'b0, next_addr_q} + (ADDR_WIDTH + 1)'(BurstBytes);

  always_comb begin
    state_d     = state_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    rready_d    = rready_q;
    next_addr_d = next_addr_q;
    beat_cnt_d  = beat_cnt_q;
    wr_bank_d   = wr_bank_q;
    resp_err_d  = resp_err_q;
    bank_set    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_i && (bank_q[wr_bank_q] == BankEmpty)) begin
          state_d   = StAddr;
          arvalid_d = 1'b1;
          araddr_d  = next_addr_q;
        end
      end
      StAddr: begin
        if (ar_fire) begin
          state_d     = StData;
          arvalid_d   = 1'b0;
          rready_d    = 1'b1;
          beat_cnt_d  = '0;
          next_addr_d = (addr_sum >= {1'b0, top_addr_i}) ? base_addr_i
                                                         : addr_sum[ADDR_WIDTH-1:0];
        end
      end
      StData: begin
        if (beat_fire) begin
          if (rresp_i != AxiRespOkay) begin
            resp_err_d = 1'b1;
          end
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) begin
            state_d   = StIdle;
            rready_d  = 1'b0;
            bank_set  = 1'b1;
            wr_bank_d = wr_bank_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (!enable_i) begin
      next_addr_d = base_addr_i;
    end
  end

  assign rd_full = (bank_q[rd_bank_q] == BankFull);
  assign serve   = data_req_i & rd_full & ~st_mode;

  always_comb begin
    rd_bank_d  = rd_bank_q;
    rd_beat_d  = rd_beat_q;
    rd_slot_d  = rd_slot_q;
    pix_bank_d = pix_bank_q;
    pix_slot_d = pix_slot_q;
    bank_clr   = 1'b0;
    if (serve) begin
      pix_bank_d = rd_bank_q;
      pix_slot_d = rd_slot_q;
      if (rd_slot_q == SlotW'(PixPerBeat - 1)) begin
        rd_slot_d = '0;
        if (rd_beat_q == BeatW'(BURST_LEN - 1)) begin
          rd_beat_d = '0;
          rd_bank_d = rd_bank_q + 1'b1;
          bank_clr  = 1'b1;
        end else begin
          rd_beat_d = rd_beat_q + 1'b1;
        end
      end else begin
        rd_slot_d = rd_slot_q + 1'b1;
      end
    end
    data_valid_d = serve | (st_mode & data_req_i);
    underrun_d   = data_req_i & ~rd_full & ~st_mode;
  end

  // Writer and reader never target the same bank in one cycle, so order here is free.
  always_comb begin
    bank_d = bank_q;
    if (bank_set) begin
      bank_d[wr_bank_q] = BankFull;
    end
    if (bank_clr) begin
      bank_d[rd_bank_q] = BankEmpty;
    end
  end

  always_ff @(posedge clk_a) begin
    if (reset_a) begin
      state_q      <= StIdle;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      rready_q     <= 1'b0;
      next_addr_q  <= base_addr_i;
      beat_cnt_q   <= '0;
      wr_bank_q    <= '0;
      resp_err_q   <= 1'b0;
      bank_q       <= '{default: BankEmpty};
      rd_bank_q    <= '0;
      rd_beat_q    <= '0;
      rd_slot_q    <= '0;
      pix_bank_q   <= '0;
      pix_slot_q   <= '0;
      data_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      rready_q     <= rready_d;
      next_addr_q  <= next_addr_d;
      beat_cnt_q   <= beat_cnt_d;
      wr_bank_q    <= wr_bank_d;
      resp_err_q   <= resp_err_d;
      bank_q       <= bank_d;
      rd_bank_q    <= rd_bank_d;
      rd_beat_q    <= rd_beat_d;
      rd_slot_q    <= rd_slot_d;
      pix_bank_q   <= pix_bank_d;
      pix_slot_q   <= pix_slot_d;
      data_valid_q <= data_valid_d;
      underrun_q   <= underrun_d;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    mbpb_bank_ram #(
      .Depth(BURST_LEN),
      .Width(DATA_WIDTH)
    ) u_ram (
      .clk_i  (clk_a),
      .rst_i  (reset_a),
      .we_i   (beat_fire && (wr_bank_q == BankW'(g))),
      .waddr_i(beat_cnt_q),
      .wdata_i(rdata_i),
      .re_i   (serve && (rd_bank_q == BankW'(g))),
      .raddr_i(rd_beat_q),
      .rdata_o(ram_rdata[g])
    );
  end

  // The RAM register holds the whole beat; the registered slot index picks the pixel.
  assign rd_word = ram_rdata[pix_bank_q];
  assign ram_pix = PIX_WIDTH'(rd_word >> (pix_slot_q * SLOT_WIDTH));

`ifdef MBPB_SELF_TEST_EN
  logic [5:0]           st_cnt_q, st_cnt_d;
  logic                 st_sel_q, st_sel_d;
  logic [PIX_WIDTH-1:0] st_pix_q, st_pix_d;

  always_comb begin
    st_cnt_d = st_cnt_q;
    st_sel_d = st_sel_q;
    st_pix_d = st_pix_q;
    if (st_mode && data_req_i) begin
      st_cnt_d = st_cnt_q + 1'b1;
      st_sel_d = 1'b1;
      st_pix_d = PIX_WIDTH'(colour_bar(st_cnt_q[5:3]));
    end else if (serve) begin
      st_sel_d = 1'b0;
    end
  end

  always_ff @(posedge clk_a) begin
    if (reset_a) begin
      st_cnt_q <= '0;
      st_sel_q <= 1'b0;
      st_pix_q <= '0;
    end else begin
      st_cnt_q <= st_cnt_d;
      st_sel_q <= st_sel_d;
      st_pix_q <= st_pix_d;
    end
  end

  assign data_o = st_sel_q ? st_pix_q : ram_pix;
`else
  assign data_o = ram_pix;
`endif

  assign data_valid_o = data_valid_q;
  assign underrun_o   = underrun_q;
  assign resp_err_o   = resp_err_q;
  assign araddr_o     = araddr_q;
  assign arvalid_o    = arvalid_q;
  assign rready_o     = rready_q;

endmodule

// File: tb/tb_multi_bank_pixel_buffer.sv
// Scoreboard bench for multi_bank_pixel_buffer with four banks: AR addresses and pixels are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_multi_bank_pixel_buffer;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned PW = 12;
  localparam int unsigned NB = 4;
  localparam int unsigned BL = 32;

  logic          clk_a = 1'b0;
  logic          reset_a, enable_i, data_req_i, arready_i, rlast_i, rvalid_i;
  logic [AW-1:0] base_addr_i, top_addr_i, araddr_o;
  logic [PW-1:0] data_o;
  logic          data_valid_o, underrun_o, resp_err_o, arvalid_o, rready_o;
  logic [7:0]    arlen_o;
  logic [2:0]    arsize_o;
  logic [1:0]    arburst_o, rresp_i;
  logic [DW-1:0] rdata_i;
`ifdef MBPB_SELF_TEST_EN
  logic          self_test_i = 1'b0;
`endif

  multi_bank_pixel_buffer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .SLOT_WIDTH(16),
    .PIX_WIDTH (PW),
    .NUM_BANKS (NB),
    .BURST_LEN (BL)
  ) dut (
    .clk_a       (clk_a),
    .reset_a     (reset_a),
    .enable_i    (enable_i),
    .base_addr_i (base_addr_i),
    .top_addr_i  (top_addr_i),
    .data_req_i  (data_req_i),
    .data_o      (data_o),
    .data_valid_o(data_valid_o),
    .underrun_o  (underrun_o),
    .resp_err_o  (resp_err_o),
    .araddr_o    (araddr_o),
    .arlen_o     (arlen_o),
    .arsize_o    (arsize_o),
    .arburst_o   (arburst_o),
    .arvalid_o   (arvalid_o),
    .arready_i   (arready_i),
    .rdata_i     (rdata_i),
    .rresp_i     (rresp_i),
    .rlast_i     (rlast_i),
    .rvalid_i    (rvalid_i),
    .rready_o    (rready_o)
`ifdef MBPB_SELF_TEST_EN
    ,
    .self_test_i (self_test_i)
`endif
  );

  always #5 clk_a = ~clk_a;

  int            n_tests = 0;
  int            n_fail = 0;
  int            n_ar = 0;
  int            n_underrun = 0;
  int            exp_underrun = 0;
  logic [AW-1:0] exp_ar_q[$];
  logic [PW-1:0] exp_pix_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every pixel and every AR handshake must match the head of its queue.
  always @(negedge clk_a) begin
    if (!reset_a) begin
      if (data_valid_o) begin
        if (exp_pix_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pixel: got 0x%0h, expected no output", data_o);
        end else begin
          check("pixel", 64'(data_o), 64'(exp_pix_q.pop_front()));
        end
      end
      if (arvalid_o && arready_i) begin
        n_ar++;
        if (exp_ar_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ar: got 0x%0h, expected no request", araddr_o);
        end else begin
          check("araddr", araddr_o, exp_ar_q.pop_front());
        end
      end
      if (underrun_o) n_underrun++;
    end
  end

  task automatic do_reset();
    @(negedge clk_a);
    reset_a    = 1'b1;
    enable_i   = 1'b0;
    data_req_i = 1'b0;
    rvalid_i   = 1'b0;
    rlast_i    = 1'b0;
    rresp_i    = 2'b00;
    rdata_i    = '0;
    repeat (3) @(negedge clk_a);
    reset_a = 1'b0;
  endtask

  // Serve one burst once rready_o rises; beat k carries tag+k in every slot.
  task automatic send_burst(input int tag, input int err_beat);
    int          w;
    logic [15:0] v;
    w = 0;
    while (!rready_o && w < 50) begin
      @(negedge clk_a);
      w++;
    end
    check("rready_wait", 64'(rready_o), 64'd1);
    if (!rready_o) return;
    for (int k = 0; k < BL; k++) begin
      v        = 16'(tag + k);
      rdata_i  = {4{v}};
      rvalid_i = 1'b1;
      rlast_i  = (k == BL - 1);
      rresp_i  = (k == err_beat) ? 2'b10 : 2'b00;
      @(negedge clk_a);
    end
    rvalid_i = 1'b0;
    rlast_i  = 1'b0;
    rresp_i  = 2'b00;
  endtask

  task automatic read_bank(input int tag);
    for (int j = 0; j < BL * 4; j++) begin
      exp_pix_q.push_back(PW'(tag + j / 4));
      data_req_i = 1'b1;
      @(negedge clk_a);
    end
    data_req_i = 1'b0;
  endtask

  initial begin
    int w;
    base_addr_i = 64'h1000;
    top_addr_i  = 64'h2000;
    arready_i   = 1'b1;
    reset_a     = 1'b1;
    enable_i    = 1'b0;
    data_req_i  = 1'b0;
    rvalid_i    = 1'b0;
    rlast_i     = 1'b0;
    rresp_i     = 2'b00;
    rdata_i     = '0;
    repeat (2) @(negedge clk_a);
    check("arlen_in_reset", 64'(arlen_o), 64'h1F);
    check("arsize_in_reset", 64'(arsize_o), 64'd3);
    check("arburst_in_reset", 64'(arburst_o), 64'd1);
    do_reset();
    @(negedge clk_a);
    check("rst_arvalid", 64'(arvalid_o), 64'd0);
    check("rst_araddr", araddr_o, 64'd0);
    check("rst_rready", 64'(rready_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_valid", 64'(data_valid_o), 64'd0);
    check("rst_underrun", 64'(underrun_o), 64'd0);
    check("rst_resp_err", 64'(resp_err_o), 64'd0);

    // Requests with every bank empty.
    for (int i = 0; i < 4; i++) begin
      data_req_i = 1'b1;
      exp_underrun++;
      @(negedge clk_a);
      check("underrun_pulse", 64'(underrun_o), 64'd1);
      check("underrun_valid", 64'(data_valid_o), 64'd0);
      check("underrun_data", 64'(data_o), 64'd0);
    end
    data_req_i = 1'b0;
    @(negedge clk_a);
    check("underrun_clear", 64'(underrun_o), 64'd0);

    // Fill all four banks, error response on beat 5 of the second burst.
    exp_ar_q.push_back(64'h1000);
    exp_ar_q.push_back(64'h1100);
    exp_ar_q.push_back(64'h1200);
    exp_ar_q.push_back(64'h1300);
    enable_i = 1'b1;
    send_burst(0, -1);
    check("resp_err_clean", 64'(resp_err_o), 64'd0);
    send_burst(32, 5);
    check("resp_err_set", 64'(resp_err_o), 64'd1);
    send_burst(64, -1);
    send_burst(96, -1);
    repeat (30) @(negedge clk_a);
    check("ar_count_stalled", 64'(n_ar), 64'd4);
    check("arvalid_stalled", 64'(arvalid_o), 64'd0);

    // Draining bank 0 frees it for the next fetch.
    exp_ar_q.push_back(64'h1400);
    read_bank(0);
    w = 0;
    while (!arvalid_o && w < 3) begin
      @(negedge clk_a);
      w++;
    end
    check("ar_after_free", 64'(arvalid_o), 64'd1);
    check("ar_free_latency_ok", 64'(w <= 1), 64'd1);
    send_burst(128, -1);
    enable_i = 1'b0;
    read_bank(32);
    read_bank(64);
    read_bank(96);
    read_bank(128);
    data_req_i = 1'b1;
    exp_underrun++;
    @(negedge clk_a);
    data_req_i = 1'b0;
    check("underrun_after_drain", 64'(underrun_o), 64'd1);
    repeat (3) @(negedge clk_a);
    check("pixels_drained", 64'(exp_pix_q.size()), 64'd0);
    check("resp_err_sticky", 64'(resp_err_o), 64'd1);

    // Address wrap on a two-burst window.
    base_addr_i = 64'h1000;
    top_addr_i  = 64'h1200;
    do_reset();
    @(negedge clk_a);
    check("resp_err_reset", 64'(resp_err_o), 64'd0);
    exp_ar_q.push_back(64'h1000);
    exp_ar_q.push_back(64'h1100);
    exp_ar_q.push_back(64'h1000);
    enable_i = 1'b1;
    send_burst(0, -1);
    send_burst(0, -1);
    send_burst(0, -1);
    enable_i = 1'b0;
    repeat (5) @(negedge clk_a);
    check("ar_drained", 64'(exp_ar_q.size()), 64'd0);
    check("underrun_total", 64'(n_underrun), 64'(exp_underrun));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
